// File: rtl/uart_prog_loader_if.sv
// Loader bus: UART byte stream and reload request in; program-memory write port, status byte
// and CPU hold out. The loader uses the master modport, the surrounding system the slave one.
interface uart_prog_loader_if #(
    parameter int unsigned ADDR_WIDTH     = 11,
    parameter int unsigned BYTES_PER_WORD = 2
);
    localparam int unsigned W = 8 * BYTES_PER_WORD;

    logic [7:0]            rx_data;
    logic                  rx_data_wr;
    logic                  reload;
    logic                  mem_wr;
    logic [ADDR_WIDTH-1:0] mem_addr;
    logic [W-1:0]          mem_wr_data;
    logic [7:0]            tx_data;
    logic                  tx_en;
    logic                  loading;
    logic                  error;

    modport master (
        input  rx_data, rx_data_wr, reload,
        output mem_wr, mem_addr, mem_wr_data, tx_data, tx_en, loading, error
    );

    modport slave (
        output rx_data, rx_data_wr, reload,
        input  mem_wr, mem_addr, mem_wr_data, tx_data, tx_en, loading, error
    );
endinterface

// File: rtl/uart_prog_loader.sv
// UART program loader: packs bytes into big-endian words, writes them to program memory from
// BASE_ADDR, checks an optional checksum, reports a status byte and releases the CPU.
module uart_prog_loader #(
    parameter int unsigned                   ADDR_WIDTH     = 11,
    parameter int unsigned                   BYTES_PER_WORD = 2,
    parameter logic [ADDR_WIDTH-1:0]         BASE_ADDR      = 'h200,
    parameter logic [ADDR_WIDTH-1:0]         ADDR_LIMIT     = ADDR_WIDTH'(2**ADDR_WIDTH - BYTES_PER_WORD),
    parameter logic [8*BYTES_PER_WORD-1:0]   END_MARK       = {BYTES_PER_WORD{8'hFF}},
    parameter bit                            CHECKSUM_EN    = 1'b1,
    parameter int unsigned                   TIMEOUT_CYCLES = 27000
) (
    input  logic               clk,
    input  logic               rst,
    uart_prog_loader_if.master bus
);
    localparam int unsigned W    = 8 * BYTES_PER_WORD;
    localparam int unsigned IDXW = (BYTES_PER_WORD > 1) ? $clog2(BYTES_PER_WORD) : 1;
    localparam int unsigned TW   = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

    localparam logic [7:0] ST_OK   = 8'h4B;
    localparam logic [7:0] ST_CSUM = 8'h45;
    localparam logic [7:0] ST_OVF  = 8'h4F;
    localparam logic [7:0] ST_TO   = 8'h54;

    typedef enum logic [1:0] {S_RECV, S_CSUM, S_ACK, S_RUN} state_t;

    state_t                state_q, state_d;
    logic [W-1:0]          word_q, word_d, word_next;
    logic [IDXW-1:0]       idx_q, idx_d;
    logic [ADDR_WIDTH-1:0] mem_addr_q, mem_addr_d, addr_cur, addr_sum;
    logic                  full_q, full_d, full_cur, addr_carry;
    logic                  mem_wr_q, mem_wr_d;
    logic [W-1:0]          mem_wr_data_q, mem_wr_data_d;
    logic [7:0]            csum_q, csum_d, word_sum;
    logic [7:0]            status_q, status_d;
    logic                  error_q, error_d;
    logic [TW-1:0]         to_q, to_d;
    logic                  byte_in, word_done, is_end, overflow, counting, timeout;
    logic                  tx_en, loading;

    always_comb begin
        byte_in   = bus.rx_data_wr && !bus.reload && (state_q == S_RECV || state_q == S_CSUM);
        word_next = (word_q << 8) | W'(bus.rx_data);
        word_done = byte_in && (state_q == S_RECV) && (idx_q == IDXW'(BYTES_PER_WORD - 1));
        is_end    = (word_next == END_MARK);
        word_sum  = '0;
        for (int unsigned i = 0; i < BYTES_PER_WORD; i++) begin
            word_sum = word_sum + word_next[8*i +: 8];
        end
        // The post-write increment lands on the same edge a following word may be judged, so the
        // overflow check sees the address as it will be after that increment. Carry-out pins the
        // address and marks memory full instead of wrapping.
        {addr_carry, addr_sum} = {1'b0, mem_addr_q} + (ADDR_WIDTH + 1)'(BYTES_PER_WORD);
        addr_cur = mem_addr_q;
        full_cur = full_q;
        if (mem_wr_q) begin
            if (addr_carry) full_cur = 1'b1;
            else            addr_cur = addr_sum;
        end
        overflow = full_cur || (addr_cur > ADDR_LIMIT);
        counting = (state_q == S_RECV && idx_q != '0) || (state_q == S_CSUM);
        timeout  = (TIMEOUT_CYCLES != 0) && counting && !bus.rx_data_wr &&
                   (to_q == TW'(TIMEOUT_CYCLES - 1));
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state_q <= S_RECV;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d  = state_q;
        status_d = status_q;
        if (bus.reload) begin
            state_d = S_RECV;
        end else begin
            case (state_q)
                S_RECV: begin
                    if (word_done && is_end) begin
                        state_d = CHECKSUM_EN ? S_CSUM : S_ACK;
                        if (!CHECKSUM_EN) status_d = ST_OK;
                    end else if (word_done && overflow) begin
                        state_d  = S_ACK;
                        status_d = ST_OVF;
                    end
                end
                S_CSUM: begin
                    if (byte_in) begin
                        state_d  = S_ACK;
                        status_d = (bus.rx_data == csum_q) ? ST_OK : ST_CSUM;
                    end else if (timeout) begin
                        state_d  = S_ACK;
                        status_d = ST_TO;
                    end
                end
                S_ACK:   state_d = (status_q == ST_OK) ? S_RUN : S_RECV;
                default: state_d = state_q;
            endcase
        end
    end

    always_comb begin
        tx_en   = (state_q == S_ACK);
        loading = (state_q != S_RUN);
    end

    always_comb begin
        word_d        = word_q;
        idx_d         = idx_q;
        mem_addr_d    = addr_cur;
        full_d        = full_cur;
        mem_wr_d      = 1'b0;
        mem_wr_data_d = mem_wr_data_q;
        csum_d        = csum_q;
        error_d       = error_q;
        to_d          = (bus.rx_data_wr || !counting || timeout || TIMEOUT_CYCLES == 0) ? '0 : to_q + 1'b1;
        if (bus.reload) begin
            word_d        = '0;
            idx_d         = '0;
            mem_addr_d    = BASE_ADDR;
            full_d        = 1'b0;
            mem_wr_data_d = '0;
            csum_d        = '0;
            error_d       = 1'b0;
            to_d          = '0;
        end else begin
            if (byte_in) error_d = 1'b0;
            if (state_q == S_RECV) begin
                if (byte_in) begin
                    word_d = word_next;
                    if (word_done) begin
                        idx_d = '0;
                        if (!is_end && !overflow) begin
                            mem_wr_d      = 1'b1;
                            mem_wr_data_d = word_next;
                            csum_d        = csum_q + word_sum;
                        end
                    end else begin
                        idx_d = idx_q + 1'b1;
                    end
                end else if (timeout) begin
                    word_d = '0;
                    idx_d  = '0;
                end
            end
            if (state_q == S_ACK && status_q != ST_OK) begin
                error_d    = 1'b1;
                mem_addr_d = BASE_ADDR;
                full_d     = 1'b0;
                csum_d     = '0;
                idx_d      = '0;
                word_d     = '0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            word_q        <= '0;
            idx_q         <= '0;
            mem_addr_q    <= BASE_ADDR;
            full_q        <= 1'b0;
            mem_wr_q      <= 1'b0;
            mem_wr_data_q <= '0;
            csum_q        <= '0;
            status_q      <= '0;
            error_q       <= 1'b0;
            to_q          <= '0;
        end else begin
            word_q        <= word_d;
            idx_q         <= idx_d;
            mem_addr_q    <= mem_addr_d;
            full_q        <= full_d;
            mem_wr_q      <= mem_wr_d;
            mem_wr_data_q <= mem_wr_data_d;
            csum_q        <= csum_d;
            status_q      <= status_d;
            error_q       <= error_d;
            to_q          <= to_d;
        end
    end

    assign bus.mem_wr      = mem_wr_q;
    assign bus.mem_addr    = mem_addr_q;
    assign bus.mem_wr_data = mem_wr_data_q;
    assign bus.tx_data     = status_q;
    assign bus.tx_en       = tx_en;
    assign bus.loading     = loading;
    assign bus.error       = error_q;
endmodule

// File: tb/tb_uart_prog_loader.sv
// Directed bench: three loader configurations share clock and reset; write and status traffic
// is logged at the falling edge and compared against hand-computed expectations.
module tb_uart_prog_loader;
    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    uart_prog_loader_if #(.ADDR_WIDTH(11), .BYTES_PER_WORD(2)) ifa ();
    uart_prog_loader_if #(.ADDR_WIDTH(11), .BYTES_PER_WORD(2)) ifb ();
    uart_prog_loader_if #(.ADDR_WIDTH(11), .BYTES_PER_WORD(1)) ifc ();

    uart_prog_loader #(.ADDR_WIDTH(11), .BYTES_PER_WORD(2)) dut_a (
        .clk(clk), .rst(rst), .bus(ifa));
    uart_prog_loader #(.ADDR_WIDTH(11), .BYTES_PER_WORD(2), .ADDR_LIMIT(11'h202)) dut_b (
        .clk(clk), .rst(rst), .bus(ifb));
    uart_prog_loader #(.ADDR_WIDTH(11), .BYTES_PER_WORD(1), .CHECKSUM_EN(1'b0)) dut_c (
        .clk(clk), .rst(rst), .bus(ifc));

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;
    int unsigned cyc = 0;
    int unsigned tx_cyc = 0;
    int unsigned fall_cyc = 0;
    logic        ld_prev = 1'b1;
    int unsigned wa_a[$], wd_a[$], tx_a[$];
    int unsigned wa_b[$], wd_b[$], tx_b[$];
    int unsigned wa_c[$], wd_c[$], tx_c[$];

    always @(negedge clk) begin
        cyc = cyc + 1;
        if (ifa.mem_wr) begin wa_a.push_back(32'(ifa.mem_addr)); wd_a.push_back(32'(ifa.mem_wr_data)); end
        if (ifb.mem_wr) begin wa_b.push_back(32'(ifb.mem_addr)); wd_b.push_back(32'(ifb.mem_wr_data)); end
        if (ifc.mem_wr) begin wa_c.push_back(32'(ifc.mem_addr)); wd_c.push_back(32'(ifc.mem_wr_data)); end
        if (ifa.tx_en) begin tx_a.push_back(32'(ifa.tx_data)); tx_cyc = cyc; end
        if (ifb.tx_en) tx_b.push_back(32'(ifb.tx_data));
        if (ifc.tx_en) tx_c.push_back(32'(ifc.tx_data));
        if (ld_prev && !ifa.loading) fall_cyc = cyc;
        ld_prev = ifa.loading;
    end

    typedef struct {
        logic        reload;
        int unsigned gap;
        int unsigned n;
        logic [7:0]  b[8];
        int unsigned nw;
        logic [10:0] wa[2];
        logic [15:0] wd[2];
        logic [7:0]  tx;
        logic        err;
        logic        ld;
    } vec_t;

    vec_t tbl[4];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: actual %0h required %0h", nm, act, exp);
        end
    endtask

    task automatic idle(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic drive(input int unsigned d, input logic [7:0] b, input logic wr, input logic rl);
        case (d)
            0: begin ifa.rx_data = b; ifa.rx_data_wr = wr; ifa.reload = rl; end
            1: begin ifb.rx_data = b; ifb.rx_data_wr = wr; ifb.reload = rl; end
            default: begin ifc.rx_data = b; ifc.rx_data_wr = wr; ifc.reload = rl; end
        endcase
    endtask

    task automatic send(input int unsigned d, input logic [7:0] b);
        @(negedge clk);
        drive(d, b, 1'b1, 1'b0);
        @(negedge clk);
        drive(d, 8'h00, 1'b0, 1'b0);
        idle(3);
    endtask

    task automatic pulse_reload(input int unsigned d);
        @(negedge clk);
        drive(d, 8'h00, 1'b0, 1'b1);
        @(negedge clk);
        drive(d, 8'h00, 1'b0, 1'b0);
        idle(2);
    endtask

    task automatic clear_logs();
        wa_a.delete(); wd_a.delete(); tx_a.delete();
        wa_b.delete(); wd_b.delete(); tx_b.delete();
        wa_c.delete(); wd_c.delete(); tx_c.delete();
        tx_cyc = 0;
        fall_cyc = 0;
    endtask

    initial begin
        // Checksum is the byte sum of the data words only: 12+34+AB+CD = 1BE -> BE; 34+56 = 8A.
        tbl[0] = '{reload: 1'b0, gap: 0, n: 7,
                   b: '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'hFF, 8'hFF, 8'h00, 8'h00},
                   nw: 2, wa: '{11'h200, 11'h202}, wd: '{16'h1234, 16'hABCD},
                   tx: 8'h45, err: 1'b1, ld: 1'b1};
        tbl[1] = '{reload: 1'b0, gap: 0, n: 7,
                   b: '{8'h12, 8'h34, 8'hAB, 8'hCD, 8'hFF, 8'hFF, 8'hBE, 8'h00},
                   nw: 2, wa: '{11'h200, 11'h202}, wd: '{16'h1234, 16'hABCD},
                   tx: 8'h4B, err: 1'b0, ld: 1'b0};
        tbl[2] = '{reload: 1'b1, gap: 27005, n: 6,
                   b: '{8'h12, 8'h34, 8'h56, 8'hFF, 8'hFF, 8'h8A, 8'h00, 8'h00},
                   nw: 1, wa: '{11'h200, 11'h000}, wd: '{16'h3456, 16'h0000},
                   tx: 8'h4B, err: 1'b0, ld: 1'b0};
        tbl[3] = '{reload: 1'b1, gap: 0, n: 3,
                   b: '{8'hFF, 8'hFF, 8'h01, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00},
                   nw: 0, wa: '{11'h000, 11'h000}, wd: '{16'h0000, 16'h0000},
                   tx: 8'h45, err: 1'b1, ld: 1'b1};

        for (int unsigned d = 0; d < 3; d++) drive(d, 8'h00, 1'b0, 1'b0);
        idle(3);
        rst = 1'b0;
        @(negedge clk);
        chk("reset mem_addr", 32'(ifa.mem_addr), 32'h200);
        chk("reset loading", 32'(ifa.loading), 32'd1);
        chk("reset mem_wr", 32'(ifa.mem_wr), 32'd0);
        chk("reset tx_en", 32'(ifa.tx_en), 32'd0);
        chk("reset error", 32'(ifa.error), 32'd0);
        chk("reset mem_wr_data", 32'(ifa.mem_wr_data), 32'd0);
        chk("reset tx_data", 32'(ifa.tx_data), 32'd0);
        chk("reset c mem_addr", 32'(ifc.mem_addr), 32'h200);

        for (int unsigned r = 0; r < 4; r++) begin
            if (tbl[r].reload) pulse_reload(0);
            clear_logs();
            for (int unsigned k = 0; k < tbl[r].n; k++) begin
                send(0, tbl[r].b[k]);
                if (k == 0 && tbl[r].gap != 0) idle(tbl[r].gap);
            end
            idle(6);
            chk($sformatf("row%0d nwrites", r), 32'(wa_a.size()), 32'(tbl[r].nw));
            for (int unsigned k = 0; k < tbl[r].nw; k++) begin
                chk($sformatf("row%0d waddr%0d", r, k), (k < wa_a.size()) ? wa_a[k] : 32'hDEADBEEF, 32'(tbl[r].wa[k]));
                chk($sformatf("row%0d wdata%0d", r, k), (k < wd_a.size()) ? wd_a[k] : 32'hDEADBEEF, 32'(tbl[r].wd[k]));
            end
            chk($sformatf("row%0d ntx", r), 32'(tx_a.size()), 32'd1);
            chk($sformatf("row%0d tx_data", r), (tx_a.size() > 0) ? tx_a[0] : 32'hDEADBEEF, 32'(tbl[r].tx));
            chk($sformatf("row%0d error", r), 32'(ifa.error), 32'(tbl[r].err));
            chk($sformatf("row%0d loading", r), 32'(ifa.loading), 32'(tbl[r].ld));
            if (!tbl[r].ld) chk($sformatf("row%0d loading fall lag", r), fall_cyc - tx_cyc, 32'd1);
        end

        // reload collides with a byte: the byte is dropped and the partial word discarded
        pulse_reload(0);
        clear_logs();
        send(0, 8'h12);
        @(negedge clk);
        drive(0, 8'h34, 1'b1, 1'b1);
        @(negedge clk);
        drive(0, 8'h00, 1'b0, 1'b0);
        idle(3);
        send(0, 8'h56); send(0, 8'h78); send(0, 8'hFF); send(0, 8'hFF); send(0, 8'hCE);
        idle(6);
        chk("collide nwrites", 32'(wa_a.size()), 32'd1);
        chk("collide waddr", (wa_a.size() > 0) ? wa_a[0] : 32'hDEADBEEF, 32'h200);
        chk("collide wdata", (wd_a.size() > 0) ? wd_a[0] : 32'hDEADBEEF, 32'h5678);
        chk("collide tx", (tx_a.size() > 0) ? tx_a[0] : 32'hDEADBEEF, 32'h4B);
        chk("collide loading", 32'(ifa.loading), 32'd0);

        clear_logs();
        send(0, 8'h11); send(0, 8'h22); send(0, 8'h33); send(0, 8'h44);
        idle(6);
        chk("run nwrites", 32'(wa_a.size()), 32'd0);
        chk("run ntx", 32'(tx_a.size()), 32'd0);
        chk("run loading", 32'(ifa.loading), 32'd0);
        chk("run mem_wr_data stable", 32'(ifa.mem_wr_data), 32'h5678);
        pulse_reload(0);
        chk("reload loading", 32'(ifa.loading), 32'd1);
        chk("reload mem_addr", 32'(ifa.mem_addr), 32'h200);

        clear_logs();
        send(0, 8'hFF); send(0, 8'hFF);
        idle(27010);
        chk("csum timeout ntx", 32'(tx_a.size()), 32'd1);
        chk("csum timeout tx", (tx_a.size() > 0) ? tx_a[0] : 32'hDEADBEEF, 32'h54);
        chk("csum timeout error", 32'(ifa.error), 32'd1);
        chk("csum timeout nwrites", 32'(wa_a.size()), 32'd0);
        chk("csum timeout loading", 32'(ifa.loading), 32'd1);
        send(0, 8'h12);
        chk("error cleared by byte", 32'(ifa.error), 32'd0);

        clear_logs();
        send(1, 8'h11); send(1, 8'h11); send(1, 8'h22); send(1, 8'h22); send(1, 8'h33); send(1, 8'h33);
        idle(6);
        chk("ovf nwrites", 32'(wa_b.size()), 32'd2);
        chk("ovf waddr0", (wa_b.size() > 0) ? wa_b[0] : 32'hDEADBEEF, 32'h200);
        chk("ovf waddr1", (wa_b.size() > 1) ? wa_b[1] : 32'hDEADBEEF, 32'h202);
        chk("ovf wdata1", (wd_b.size() > 1) ? wd_b[1] : 32'hDEADBEEF, 32'h2222);
        chk("ovf tx", (tx_b.size() > 0) ? tx_b[0] : 32'hDEADBEEF, 32'h4F);
        chk("ovf error", 32'(ifb.error), 32'd1);
        chk("ovf mem_addr", 32'(ifb.mem_addr), 32'h200);

        send(2, 8'h5A); send(2, 8'hFF);
        idle(6);
        chk("bpw1 nwrites", 32'(wa_c.size()), 32'd1);
        chk("bpw1 waddr", (wa_c.size() > 0) ? wa_c[0] : 32'hDEADBEEF, 32'h200);
        chk("bpw1 wdata", (wd_c.size() > 0) ? wd_c[0] : 32'hDEADBEEF, 32'h5A);
        chk("bpw1 tx", (tx_c.size() > 0) ? tx_c[0] : 32'hDEADBEEF, 32'h4B);
        chk("bpw1 loading", 32'(ifc.loading), 32'd0);

        // dut_a holds a partial word (byte 12) when reset hits
        @(negedge clk);
        rst = 1'b1;
        idle(2);
        chk("midrst mem_addr", 32'(ifa.mem_addr), 32'h200);
        chk("midrst loading", 32'(ifa.loading), 32'd1);
        chk("midrst tx_data", 32'(ifa.tx_data), 32'd0);
        chk("midrst mem_wr_data", 32'(ifa.mem_wr_data), 32'd0);
        chk("midrst b error", 32'(ifb.error), 32'd0);
        chk("midrst b tx_data", 32'(ifb.tx_data), 32'd0);
        chk("midrst c loading", 32'(ifc.loading), 32'd1);
        chk("midrst c tx_data", 32'(ifc.tx_data), 32'd0);
        rst = 1'b0;
        clear_logs();
        send(0, 8'h34); send(0, 8'h56); send(0, 8'hFF); send(0, 8'hFF); send(0, 8'h8A);
        idle(6);
        chk("postrst nwrites", 32'(wa_a.size()), 32'd1);
        chk("postrst wdata", (wd_a.size() > 0) ? wd_a[0] : 32'hDEADBEEF, 32'h3456);
        chk("postrst tx", (tx_a.size() > 0) ? tx_a[0] : 32'hDEADBEEF, 32'h4B);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
